dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single data memory port between two requesters: req 0 = core LD/ST path, req 1 = network debug/DMA path.
- Both requesters use the core's valid/yumi dmem handshake.
- One transaction is outstanding at a time; on contention, grant alternates round-robin.
- Sits between the core's to_mem_o/from_mem_i structs and the dmem. Includes a response-timeout watchdog that raises a sticky error.

Parameters:
- timeout_p, 255: maximum cycles to wait in RESP before timeout_o is set; legal range 1..65535.
- addr_width_p, 32: width of the request address.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- req_valid_i  input  2  request valid per requester, held until req_yumi_o
- req_wen_i  input  2  per-requester store flag
- req_byte_i  input  2  per-requester byte_not_word
- req_addr_i  input  2 x addr_width_p  per-requester address
- req_wdata_i  input  2 x 32  per-requester write data
- req_yumi_o  output  2  request accepted, one-hot, one cycle
- resp_valid_o  output  2  response valid, one-hot to owner
- resp_data_o  output  32  read data, shared by both requesters
- resp_yumi_i  input  2  owner consumes response
- mem_valid_o  output  1  request to dmem
- mem_wen_o  output  1  store flag to dmem
- mem_byte_o  output  1  byte_not_word to dmem
- mem_addr_o  output  addr_width_p  address to dmem
- mem_wdata_o  output  32  write data to dmem
- mem_yumi_i  input  1  dmem accepted request
- mem_valid_i  input  1  dmem response valid
- mem_rdata_i  input  32  dmem read data
- mem_yumi_o  output  1  arbiter consumes dmem response
- owner_o  output  1  requester currently holding the grant
- busy_o  output  1  state != IDLE
- timeout_o  output  1  sticky watchdog error

Behaviour:
- Reset values: state = IDLE, owner = 0, last_grant = 1 (so core wins the first tie), latched request fields = 0, timeout counter = 0, timeout_o = 0. All handshake outputs are 0 during reset.
- States: IDLE, REQ, RESP.
- IDLE:
  - If any req_valid_i is set, choose the winner: the only valid requester; if both are valid, the one != last_grant.
  - Same cycle: req_yumi_o[winner] = 1; latch wen, byte, addr and wdata; owner <= winner; go to REQ.
  - If no request is valid, stay in IDLE.
- REQ:
  - mem_valid_o = 1, driving the latched fields.
  - On mem_yumi_i, go to RESP and clear the counter.
  - mem_* fields must not change while mem_valid_o = 1.
- RESP:
  - resp_valid_o[owner] = mem_valid_i; resp_data_o = mem_rdata_i (combinational pass-through).
  - mem_yumi_o = mem_valid_i & resp_yumi_i[owner].
  - When mem_yumi_o is asserted: last_grant <= owner, go to IDLE.
  - The earliest next grant is the following cycle (minimum 3 cycles per transaction).
- Stores also wait for the mem_valid_i ack in RESP; there is no special-casing of stores.
- Watchdog:
  - The counter increments each RESP cycle without mem_valid_i and saturates at its maximum.
  - When the counter reaches timeout_p, timeout_o <= 1. It remains set until reset.
  - The state machine stays in RESP; the hang is not aborted.
- Ignored signals:
  - resp_yumi_i from the non-owner is ignored.
  - mem_valid_i outside RESP is ignored and is not acked.
  - mem_yumi_i outside REQ is ignored.
- A requester that drops req_valid_i before being granted is legal; it is simply not granted.
- resp_valid_o and req_yumi_o are never both set for the same requester in the same cycle.
- Asynchronous reset mid-transaction returns to IDLE immediately. No response is delivered and no mem_yumi_o is issued.
- owner_o and busy_o are registered state, not combinational.

Test Plan:
- Single core load: req_valid_i = 01, addr 0x40; mem_yumi_i at cycle 2; mem_valid_i with rdata 0xDEADBEEF at cycle 4; resp_yumi_i = 01 -> req_yumi_o = 01 at cycle 0, mem_valid_o during cycles 1-2, resp_valid_o = 01 with data 0xDEADBEEF, then IDLE at cycle 5.
- Simultaneous requests after reset: req_valid_i = 11 held -> core (0) is granted first and net (1) second. Repeat with both valid again -> grants stay 0,1,0,1.
- Back-to-back core-only requests -> core is granted every transaction despite last_grant = 0; each grant arrives exactly 1 cycle after the previous IDLE return.
- Owner stall: mem_valid_i held for 3 cycles while resp_yumi_i = 00 -> mem_yumi_o = 0 and the response stays presented; resp_yumi_i = 10 (non-owner) has no effect; resp_yumi_i = 01 -> ack, return to IDLE.
- Watchdog: timeout_p = 4, mem_valid_i never asserted in RESP -> timeout_o rises after 4 RESP cycles and stays 1 after a later response completes.
- Reset asserted during RESP -> all outputs 0 immediately. After reset release, the next request is granted to core on tie.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter for the single data-memory port.
// Keeps one transaction outstanding and raises a sticky error if a response never arrives.
module dmem_arbiter #(
   parameter int unsigned timeout_p    = 255,
   parameter int unsigned addr_width_p = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [1:0]                   req_valid_i,
   input  logic [1:0]                   req_wen_i,
   input  logic [1:0]                   req_byte_i,
   input  logic [1:0][addr_width_p-1:0] req_addr_i,
   input  logic [1:0][31:0]             req_wdata_i,
   output logic [1:0]                   req_yumi_o,
   output logic [1:0]                   resp_valid_o,
   output logic [31:0]                  resp_data_o,
   input  logic [1:0]                   resp_yumi_i,
   output logic                         mem_valid_o,
   output logic                         mem_wen_o,
   output logic                         mem_byte_o,
   output logic [addr_width_p-1:0]      mem_addr_o,
   output logic [31:0]                  mem_wdata_o,
   input  logic                         mem_yumi_i,
   input  logic                         mem_valid_i,
   input  logic [31:0]                  mem_rdata_i,
   output logic                         mem_yumi_o,
   output logic                         owner_o,
   output logic                         busy_o,
   output logic                         timeout_o
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

   localparam logic [16:0] timeout_lim = 17'(timeout_p);

   state_e                  state, state_next;
   logic                    owner, last_grant, winner, grant, ack;
   logic                    wen, byte_nw, timeout;
   logic [addr_width_p-1:0] addr;
   logic [31:0]             wdata;
   logic [15:0]             cnt;
   logic [16:0]             cnt_inc;

   assign cnt_inc = {1'b0, cnt} + 17'd1;

   always_comb begin
      state_next   = state;
      grant        = 1'b0;
      winner       = 1'b0;
      ack          = 1'b0;
      req_yumi_o   = '0;
      resp_valid_o = '0;
      case (state)
         IDLE: begin
            if (|req_valid_i) begin
               // On a tie the requester that did not win last time goes first.
               winner             = (&req_valid_i) ? ~last_grant : req_valid_i[1];
               grant              = 1'b1;
               req_yumi_o[winner] = reset;
               state_next         = REQ;
            end
         end
         REQ: begin
            if (mem_yumi_i) state_next = RESP;
         end
         RESP: begin
            resp_valid_o[owner] = mem_valid_i;
            ack                 = mem_valid_i & resp_yumi_i[owner];
            if (ack) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         wen        <= 1'b0;
         byte_nw    <= 1'b0;
         addr       <= '0;
         wdata      <= '0;
         cnt        <= '0;
         timeout    <= 1'b0;
      end else begin
         state <= state_next;
         if (grant) begin
            owner   <= winner;
            wen     <= req_wen_i[winner];
            byte_nw <= req_byte_i[winner];
            addr    <= req_addr_i[winner];
            wdata   <= req_wdata_i[winner];
         end
         if (ack) last_grant <= owner;
         if (state == REQ && mem_yumi_i) begin
            cnt <= '0;
         end else if (state == RESP && !mem_valid_i) begin
            if (cnt != '1) cnt <= cnt + 16'd1;
            if (cnt_inc >= timeout_lim) timeout <= 1'b1;
         end
      end
   end

   assign mem_valid_o = (state == REQ);
   assign mem_wen_o   = wen;
   assign mem_byte_o  = byte_nw;
   assign mem_addr_o  = addr;
   assign mem_wdata_o = wdata;
   assign mem_yumi_o  = ack;
   assign resp_data_o = mem_rdata_i;
   assign owner_o     = owner;
   assign busy_o      = (state != IDLE);
   assign timeout_o   = timeout;

endmodule
